// File: rtl/cpu_bus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module : cpu_bus_bridge_if
// System-side request/acknowledge bus driven by cpu_bus_bridge.
// Rev    : 1.0
// ============================================================================
interface cpu_bus_bridge_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_dat;
  logic          o_we;
  logic          o_stb;
  logic [DW-1:0] i_dat;
  logic          i_ack;
  logic          i_active;

  // Signal names follow the bridge's point of view.
  modport master (
    output o_addr, o_dat, o_we, o_stb,
    input  i_dat, i_ack, i_active
  );

  modport slave (
    input  o_addr, o_dat, o_we, o_stb,
    output i_dat, i_ack, i_active
  );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module : cpu_bus_bridge
// 6502 combinational bus to strobe/ack system bus bridge with IRQ/NMI
// synchronisers. Optional ack timeout enabled by macro CPU_BUS_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module cpu_bus_bridge #(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [AW-1:0]    i_cpu_addr,
  input  logic [DW-1:0]    i_cpu_dat,
  input  logic             i_cpu_we,
  output logic [DW-1:0]    o_cpu_dat,
  output logic             o_cpu_rdy,
  output logic             o_cpu_irq,
  output logic             o_cpu_nmi,
  input  logic             i_int,
  input  logic             i_nmi,
  cpu_bus_bridge_if.master bus,
  output logic             o_bus_err
);

  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_param_check
    $error("cpu_bus_bridge: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          dat_q, dat_d;
  logic                   we_q, we_d;
  logic                   stb_q, stb_d;
  logic [DW-1:0]          cpu_dat_q, cpu_dat_d;
  logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  // Fire on the edge where the count would step to TIMEOUT.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    stb_d      = stb_q;
    cpu_dat_d  = cpu_dat_q;
    irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], i_int};
    nmi_sync_d = {nmi_sync_q[SYNC_STAGES-2:0], i_nmi};
`ifdef CPU_BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        addr_d  = i_cpu_addr;
        dat_d   = i_cpu_dat;
        we_d    = i_cpu_we;
        stb_d   = 1'b1;
        state_d = S_WAIT;
`ifdef CPU_BUS_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (bus.i_ack && bus.i_active) begin
          if (!we_q) cpu_dat_d = bus.i_dat;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end
`ifdef CPU_BUS_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          if (!we_q) cpu_dat_d = '1;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      stb_q      <= 1'b0;
      cpu_dat_q  <= '0;
      irq_sync_q <= '0;
      nmi_sync_q <= '0;
`ifdef CPU_BUS_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      stb_q      <= stb_d;
      cpu_dat_q  <= cpu_dat_d;
      irq_sync_q <= irq_sync_d;
      nmi_sync_q <= nmi_sync_d;
`ifdef CPU_BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // RDY decodes registered state only, so i_ack never reaches the core combinationally.
  assign o_cpu_rdy  = (state_q == S_DONE);
  assign o_cpu_dat  = cpu_dat_q;
  assign o_cpu_irq  = irq_sync_q[SYNC_STAGES-1];
  assign o_cpu_nmi  = nmi_sync_q[SYNC_STAGES-1];
  assign bus.o_addr = addr_q;
  assign bus.o_dat  = dat_q;
  assign bus.o_we   = we_q;
  assign bus.o_stb  = stb_q;

`ifdef CPU_BUS_TIMEOUT_EN
  assign o_bus_err  = err_q;
`else
  assign o_bus_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Parametrised bus bridge between the 6502 core's combinational bus (AD/DO/WE, sampled DI, RDY stall) and the system request/acknowledge bus.
- Registers the address, write data and write enable, and runs a strobe/ack handshake that is gated by bus grant (i_active).
- Stalls the core through RDY until the access completes.
- Also synchronises the IRQ and NMI inputs into the CPU clock domain.

Parameters:
- AW, 16, address width (CPU and system side).
- DW, 8, data width.
- SYNC_STAGES, 2, flip-flop stages on i_int/i_nmi; minimum 2.
- TIMEOUT, 255, ack timeout in cycles; used only when CPU_BUS_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; one clock, reset is asynchronous and active-high.
- i_cpu_addr  in  AW  core address (combinational).
- i_cpu_dat  in  DW  core write data.
- i_cpu_we  in  1  core write enable.
- o_cpu_dat  out  DW  read data to core DI.
- o_cpu_rdy  out  1  core RDY; 0 stalls the core.
- o_cpu_irq  out  1  synchronised i_int.
- o_cpu_nmi  out  1  synchronised i_nmi.
- o_addr  out  AW  registered bus address.
- o_dat  out  DW  registered bus write data.
- o_we  out  1  registered bus write enable.
- o_stb  out  1  bus request strobe.
- i_dat  in  DW  bus read data.
- i_ack  in  1  bus acknowledge.
- i_active  in  1  bus grant; ack is ignored while 0.
- o_bus_err  out  1  sticky timeout flag; constant 0 without the macro.

Behaviour:
- Reset values (async): state IDLE; o_stb=0, o_we=0, o_addr=0, o_dat=0, o_cpu_dat=0, o_cpu_rdy=0, o_bus_err=0, all sync flops 0.
- FSM states IDLE, WAIT, DONE. o_cpu_rdy=1 only in DONE (registered state decode, no combinational path from i_ack).
- IDLE:
  - Capture i_cpu_addr/i_cpu_dat/i_cpu_we into o_addr/o_dat/o_we.
  - Set o_stb<=1; go to WAIT.
  - Every IDLE cycle starts an access; the core always accesses.
- WAIT:
  - o_stb stays 1; o_addr/o_dat/o_we are held stable.
  - Access completes on the edge where i_ack && i_active: o_cpu_dat<=i_dat (reads only; writes leave o_cpu_dat unchanged), o_stb<=0, o_we<=0, go to DONE.
  - i_ack with i_active=0 is ignored and the bridge stays in WAIT.
- DONE:
  - o_cpu_rdy=1 for exactly one cycle; o_cpu_dat holds the captured read data.
  - Next state IDLE.
- Latency: zero-wait ack gives 3 cycles per access (IDLE, WAIT, DONE). Each extra wait cycle or ungranted cycle adds 1.
- o_stb is deasserted for at least the DONE and IDLE cycles between accesses; no back-to-back strobes.
- Address and write data are sampled only in IDLE. Changes on i_cpu_* during WAIT/DONE have no effect.
- Interrupts:
  - o_cpu_irq is i_int through SYNC_STAGES flops; o_cpu_nmi is i_nmi through SYNC_STAGES flops.
  - Latency is SYNC_STAGES cycles.
  - Synchronisers are independent of the FSM and keep running while stalled.
- Reset mid-access: o_stb drops immediately (async) and the FSM returns to IDLE. The first access after reset release starts on the first clock edge.
- Simultaneous i_ack and i_reset: reset wins.

Optional Feature:
- Macro CPU_BUS_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT+1) bits clears on entry to WAIT and increments each WAIT cycle without completion.
  - When the count reaches TIMEOUT: force completion with o_cpu_dat<=all ones (reads), o_stb<=0, o_bus_err<=1, go to DONE.
  - o_bus_err is cleared only by reset.
  - Ack on the same edge as the timeout takes priority as a normal completion and does not set o_bus_err.
- Not defined: no counter; WAIT lasts indefinitely; o_bus_err is tied 0.

Test Plan:
- Reset: hold i_reset with i_ack=1 -> o_stb=0, o_cpu_rdy=0, o_cpu_dat=0x00. Release -> o_stb=1 one edge later with o_addr=i_cpu_addr.
- Read zero-wait: addr 0xFFFC, i_ack=1, i_active=1, i_dat=0x34 -> o_stb high 1 cycle, o_cpu_rdy high 1 cycle at cycle 3, o_cpu_dat=0x34; next access starts cycle 4.
- Write with 2 wait cycles: addr 0x0200, dat 0xA5, we=1 -> o_we=1 and o_dat=0xA5 stable for 3 strobe cycles; o_cpu_rdy pulses once; o_cpu_dat unchanged.
- Grant gating: i_ack=1, i_active=0 for 5 cycles, then i_active=1 -> completion exactly 1 edge after i_active rises; o_addr never changes meanwhile.
- Interrupts: i_int pulse 0->1 with SYNC_STAGES=2 -> o_cpu_irq rises after 2 edges. i_nmi level during a stall still propagates.
- Timeout (macro defined, TIMEOUT=4): never ack -> after 4 WAIT cycles o_cpu_dat=0xFF, o_bus_err=1 sticky, o_cpu_rdy pulse. Asserting reset mid-WAIT clears o_bus_err and o_stb asynchronously.
